// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store definitions: funct3 width codes, error codes, sequencer states
// and the captured request payload.
package lsu_ctrl_pkg;

    localparam logic [2:0] LOAD_B  = 3'b000;
    localparam logic [2:0] LOAD_H  = 3'b001;
    localparam logic [2:0] LOAD_W  = 3'b010;
    localparam logic [2:0] LOAD_BU = 3'b100;
    localparam logic [2:0] LOAD_HU = 3'b101;

    localparam logic [2:0] STORE_B = 3'b000;
    localparam logic [2:0] STORE_H = 3'b001;
    localparam logic [2:0] STORE_W = 3'b010;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        LSU_OK         = 2'b00,
        LSU_MISALIGNED = 2'b01,
        LSU_TIMEOUT    = 2'b10,
        LSU_ILLEGAL    = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MEM_WAIT = 2'b01,
        RESP     = 2'b10
    } lsu_state_e;

    typedef struct packed {
        logic            is_store;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
    } lsu_req_t;

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane logic: store enables/replication, load extraction/extension,
// and funct3 legality and alignment checks.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic            is_store,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] ld_data,
    output logic            misaligned,
    output logic            illegal
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{addr, 3'b000} +: 8];
    assign lane_h = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        ld_data    = rdata;
        misaligned = 1'b0;
        illegal    = 1'b0;
        if (is_store) begin
            unique case (funct3)
                STORE_B: begin
                    be        = 4'b0001 << addr;
                    wdata_rep = {4{wdata[7:0]}};
                end
                STORE_H: begin
                    be         = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_rep  = {2{wdata[15:0]}};
                    misaligned = addr[0];
                end
                STORE_W: misaligned = |addr;
                default: illegal = 1'b1;
            endcase
        end else begin
            unique case (funct3)
                LOAD_B:  ld_data = {{24{lane_b[7]}}, lane_b};
                LOAD_BU: ld_data = {24'h000000, lane_b};
                LOAD_H: begin
                    ld_data    = {{16{lane_h[15]}}, lane_h};
                    misaligned = addr[0];
                end
                LOAD_HU: begin
                    ld_data    = {16'h0000, lane_h};
                    misaligned = addr[0];
                end
                LOAD_W:  misaligned = |addr;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one op, runs a req/ack bus transfer with an
// optional ack timeout, and returns a single-cycle writeback response.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_is_store_o,
    output logic [4:0]  rsp_rd_o,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_err_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    lsu_req_t        req_q, req_in, al_src;
    logic [CNT_W-1:0] cnt_q;
    logic            rsp_store_q;
    logic [4:0]      rsp_rd_q;
    logic [XLEN-1:0] rsp_data_q;
    lsu_err_e        rsp_err_q;

    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_ld_data;
    logic            al_misaligned;
    logic            al_illegal;
    logic            timeout_hit;

    assign req_in = '{is_store: req_is_store_i, funct3: req_funct3_i, addr: req_addr_i,
                      wdata: req_wdata_i, rd: req_rd_i};

    // In IDLE the lane logic checks the incoming op; afterwards it works from the capture.
    assign al_src = (state_q == IDLE) ? req_in : req_q;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    lsu_align u_align (
        .funct3     (al_src.funct3),
        .addr       (al_src.addr[1:0]),
        .is_store   (al_src.is_store),
        .wdata      (al_src.wdata),
        .rdata      (mem_rdata_i),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .ld_data    (al_ld_data),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = (al_illegal || al_misaligned) ? RESP : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, wait counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q       <= '0;
            cnt_q       <= '0;
            rsp_store_q <= 1'b0;
            rsp_rd_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= LSU_OK;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q       <= req_in;
                        cnt_q       <= '0;
                        rsp_store_q <= req_is_store_i;
                        rsp_rd_q    <= '0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= al_illegal    ? LSU_ILLEGAL :
                                       al_misaligned ? LSU_MISALIGNED : LSU_OK;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        if (!req_q.is_store) begin
                            rsp_rd_q   <= req_q.rd;
                            rsp_data_q <= al_ld_data;
                        end
                    end else if (timeout_hit) begin
                        rsp_err_q <= LSU_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready_o    = 1'b0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_be_o       = '0;
        mem_wdata_o    = '0;
        rsp_valid_o    = 1'b0;
        rsp_is_store_o = 1'b0;
        rsp_rd_o       = '0;
        rsp_data_o     = '0;
        rsp_err_o      = '0;
        unique case (state_q)
            IDLE: req_ready_o = 1'b1;
            MEM_WAIT: begin
                mem_req_o   = 1'b1;
                mem_we_o    = req_q.is_store;
                mem_addr_o  = {req_q.addr[31:2], 2'b00};
                mem_be_o    = al_be;
                mem_wdata_o = al_wdata;
            end
            RESP: begin
                rsp_valid_o    = 1'b1;
                rsp_is_store_o = rsp_store_q;
                rsp_rd_o       = rsp_rd_q;
                rsp_data_o     = rsp_data_q;
                rsp_err_o      = rsp_err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: transaction-level expectations per cycle,
// directed cases with literal pins, then randomized traffic.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_is_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        rsp_valid_o, rsp_is_store_o;
    logic [4:0]  rsp_rd_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_err_o;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_is_store_i(req_is_store_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_is_store_o(rsp_is_store_o),
        .rsp_rd_o(rsp_rd_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        chk_en = 1'b0;
    logic        exp_ready, exp_mem_req, exp_we, exp_rsp_valid, exp_rsp_store;
    logic [31:0] exp_addr, exp_wdata, exp_rsp_data;
    logic [3:0]  exp_be;
    logic [4:0]  exp_rsp_rd;
    logic [1:0]  exp_rsp_err;

    int          hold_cnt = 0;
    logic [3:0]  last_be;
    logic [31:0] last_wd, last_data;
    logic [1:0]  last_err;
    logic [4:0]  last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules written directly from the access-width tables.
    function automatic logic [1:0] ref_err(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 2'b11;
        if (f3[1:0] == 2'd1 && a[0]) return 2'b01;
        if (f3[1:0] == 2'd2 && a != 2'd0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] ref_be(input logic st, input logic [2:0] f3, input logic [1:0] a);
        if (!st) return 4'hF;
        case (f3)
            3'd0:    return 4'(1 << a);
            3'd1:    return a[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    return {4{w[7:0]}};
            3'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_ld(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] r);
        logic [31:0] sh;
        case (f3[1:0])
            2'd0: begin
                sh = r >> (8 * a);
                return f3[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'd1: begin
                sh = r >> (16 * a[1]);
                return f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: return r;
        endcase
    endfunction

    task automatic exp_idle();
        exp_ready = 1'b1; exp_mem_req = 1'b0; exp_we = 1'b0;
        exp_addr = '0; exp_be = '0; exp_wdata = '0;
        exp_rsp_valid = 1'b0; exp_rsp_store = 1'b0; exp_rsp_rd = '0;
        exp_rsp_data = '0; exp_rsp_err = '0;
    endtask

    // Every-cycle comparison of DUT outputs against the current expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready_o), 32'(exp_ready));
            check("mem_req", 32'(mem_req_o), 32'(exp_mem_req));
            if (exp_mem_req) begin
                check("mem_we", 32'(mem_we_o), 32'(exp_we));
                check("mem_addr", mem_addr_o, exp_addr);
                check("mem_be", 32'(mem_be_o), 32'(exp_be));
                if (exp_we) check("mem_wdata", mem_wdata_o, exp_wdata);
            end
            check("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp_valid));
            check("rsp_is_store", 32'(rsp_is_store_o), 32'(exp_rsp_store));
            check("rsp_rd", 32'(rsp_rd_o), 32'(exp_rsp_rd));
            check("rsp_data", rsp_data_o, exp_rsp_data);
            check("rsp_err", 32'(rsp_err_o), 32'(exp_rsp_err));
        end
    end

    always @(negedge clk) begin
        if (mem_req_o) begin
            hold_cnt++;
            last_be = mem_be_o;
            last_wd = mem_wdata_o;
        end
        if (rsp_valid_o) begin
            last_err  = rsp_err_o;
            last_data = rsp_data_o;
            last_rd   = rsp_rd_o;
        end
    end

    // One complete operation; ack_at = wait cycle index carrying the ack (large = never).
    task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd,
                      input logic [31:0] rdata, input int ack_at);
        logic [1:0] err;
        logic       acked, done;
        int         w;
        err = ref_err(st, f3, addr[1:0]);
        @(posedge clk); #1;
        exp_idle();
        hold_cnt       = 0;
        req_valid_i    = 1'b1;
        req_is_store_i = st;
        req_funct3_i   = f3;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_rd_i       = rd;
        mem_ack_i      = 1'($urandom_range(0, 1));
        mem_rdata_i    = $urandom;
        @(posedge clk); #1;
        req_valid_i  = 1'b0;
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
        req_funct3_i = 3'($urandom_range(0, 7));
        if (err != 2'b00) begin
            mem_ack_i = 1'($urandom_range(0, 1));
            exp_idle();
            exp_ready = 1'b0;
            exp_rsp_valid = 1'b1; exp_rsp_store = st; exp_rsp_err = err;
        end else begin
            exp_idle();
            exp_ready = 1'b0; exp_mem_req = 1'b1; exp_we = st;
            exp_addr  = {addr[31:2], 2'b00};
            exp_be    = ref_be(st, f3, addr[1:0]);
            exp_wdata = ref_wd(f3, wdata);
            w = 0; acked = 1'b0; done = 1'b0;
            while (!done) begin
                acked       = (w == ack_at);
                mem_ack_i   = acked;
                mem_rdata_i = acked ? rdata : $urandom;
                done = acked || (w == int'(TO) - 1);
                if (!done) begin
                    @(posedge clk); #1;
                    w++;
                end
            end
            @(posedge clk); #1;
            mem_ack_i = 1'b0;
            exp_idle();
            exp_ready = 1'b0;
            exp_rsp_valid = 1'b1; exp_rsp_store = st;
            exp_rsp_err   = acked ? 2'b00 : 2'b10;
            exp_rsp_rd    = (acked && !st) ? rd : 5'd0;
            exp_rsp_data  = (acked && !st) ? ref_ld(f3, addr[1:0], rdata) : 32'd0;
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_is_store_i = 1'b0; req_funct3_i = '0;
        req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        exp_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_be", 32'(mem_be_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data", rsp_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        op(1'b0, LOAD_W, 32'h0000_0100, 32'h0, 5'd7, 32'hDEAD_BEEF, 0);
        settle();
        check("lw_data", last_data, 32'hDEAD_BEEF);
        check("lw_rd", 32'(last_rd), 32'd7);
        check("lw_hold", 32'(hold_cnt), 32'd1);

        op(1'b0, LOAD_B, 32'h0000_0203, 32'h0, 5'd3, 32'h80AA_BBCC, 0);
        settle();
        check("lb_data", last_data, 32'hFFFF_FF80);
        op(1'b0, LOAD_BU, 32'h0000_0203, 32'h0, 5'd3, 32'h80AA_BBCC, 1);
        settle();
        check("lbu_data", last_data, 32'h0000_0080);

        op(1'b1, STORE_H, 32'h0000_0302, 32'h1234_ABCD, 5'd9, 32'h0, 3);
        settle();
        check("sh_be", 32'(last_be), 32'h0000_000C);
        check("sh_wdata", last_wd, 32'hABCD_ABCD);
        check("sh_hold", 32'(hold_cnt), 32'd4);
        check("sh_rd", 32'(last_rd), 32'd0);

        op(1'b0, LOAD_W, 32'h0000_0101, 32'h0, 5'd4, 32'h0, 0);
        settle();
        check("mis_err", 32'(last_err), 32'd1);
        check("mis_hold", 32'(hold_cnt), 32'd0);
        op(1'b1, 3'b011, 32'h0000_0101, 32'h0, 5'd4, 32'h0, 0);
        settle();
        check("ill_err", 32'(last_err), 32'd3);

        op(1'b0, LOAD_W, 32'h0000_0500, 32'h0, 5'd6, 32'h0, 99);
        settle();
        check("to_err", 32'(last_err), 32'd2);
        check("to_hold", 32'(hold_cnt), 32'd4);
        op(1'b0, LOAD_W, 32'h0000_0504, 32'h0, 5'd6, 32'h1357_9BDF, 3);
        settle();
        check("late_ack_err", 32'(last_err), 32'd0);
        check("late_ack_data", last_data, 32'h1357_9BDF);

        // Async reset in the middle of a bus wait, then a stray ack.
        @(posedge clk); #1;
        exp_idle();
        req_valid_i = 1'b1; req_is_store_i = 1'b0; req_funct3_i = LOAD_W;
        req_addr_i = 32'h0000_0400; req_rd_i = 5'd2;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        exp_ready = 1'b0; exp_mem_req = 1'b1; exp_we = 1'b0;
        exp_addr = 32'h0000_0400; exp_be = 4'hF;
        @(negedge clk); #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_mem_req", 32'(mem_req_o), 32'd0);
        check("arst_ready", 32'(req_ready_o), 32'd1);
        mem_ack_i = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        exp_idle();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ack_i = 1'b0;

        for (int i = 0; i < 200; i++) begin
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
               5'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 5)));
        end

        @(posedge clk); #1;
        exp_idle();
        settle();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the execute stage and a single-port data-memory bus with a req/ack handshake.
- Accepts one load or store at a time and checks funct3 and alignment.
- Drives byte enables and replicated write data; extracts and sign/zero-extends load data.
- Enforces an ack timeout, then returns a one-cycle response to writeback.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles mem_req_o stays high awaiting ack; 0 disables the timeout.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
req_valid_i  in  1  execute stage presents a memory op.
req_ready_o  out  1  block can accept a request (IDLE only).
req_is_store_i  in  1  1 = store, 0 = load.
req_funct3_i  in  3  load/store width code.
req_addr_i  in  32  byte address.
req_wdata_i  in  32  store data (rs2).
req_rd_i  in  5  load destination register.
mem_req_o  out  1  bus request, held until ack or timeout.
mem_we_o  out  1  write strobe.
mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
mem_be_o  out  4  byte enables.
mem_wdata_o  out  32  lane-replicated store data.
mem_ack_i  in  1  bus completion; rdata valid same cycle for loads.
mem_rdata_i  in  32  read word.
rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
rsp_is_store_o  out  1  response belongs to a store.
rsp_rd_o  out  5  destination register (0 for stores and errors).
rsp_data_o  out  32  extended load data (0 for stores and errors).
rsp_err_o  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - All outputs 0 except req_ready_o=1.
  - Timeout counter and captured request cleared.
  - mem_req_o drops the moment rst asserts, including mid-transaction.
  - An ack arriving after reset is ignored.
- States: IDLE, MEM_WAIT, RESP.
- IDLE:
  - req_ready_o=1. Acceptance = req_valid_i & req_ready_o.
  - The request is registered on acceptance.
  - If funct3 is illegal → RESP with err 11. Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Else if misaligned → RESP with err 01. Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠00.
  - Else → MEM_WAIT.
  - Illegal funct3 takes priority over misalignment.
- MEM_WAIT:
  - mem_req_o=1 and the mem_* outputs are held stable from registered values.
  - mem_ack_i=1 → capture the response (load data extracted from mem_rdata_i), then → RESP.
  - Counter increments each cycle without ack. When TIMEOUT_CYCLES≠0 and mem_req_o has been high TIMEOUT_CYCLES cycles with no ack → RESP with err 10.
  - An ack on the final permitted cycle wins over timeout.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE. rsp_* are 0 whenever rsp_valid_o=0.
- Latency:
  - Accepted at cycle T → mem_req_o high at T+1.
  - Zero-wait ack at T+1 → rsp_valid_o at T+2.
  - Error paths → rsp_valid_o at T+1.
  - Next acceptance is possible in the cycle after RESP.
- mem_ack_i while mem_req_o=0 is ignored.
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - Loads drive be = 1111 and we = 0.
- Load extract:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. Reset to 0 on entering MEM_WAIT.

Decomposition:
- Shared proc package additions:
  - STORE_B=3'b000, STORE_H=3'b001, STORE_W=3'b010.
  - lsu_err_e (OK, MISALIGNED, TIMEOUT, ILLEGAL).
  - lsu_state_e (IDLE, MEM_WAIT, RESP).
  - Reuse the existing LOAD_* constants.
- One combinational sub-module, lsu_align:
  - Inputs: funct3, addr[1:0], is_store, wdata, rdata.
  - Outputs: be, replicated wdata, extended load data, misaligned, illegal.

Test Plan:
- Zero-wait LW: addr 0x100, rdata 0xDEADBEEF, ack on first req cycle → mem_addr 0x100, be 1111; rsp at T+2 with data 0xDEADBEEF, rd echoed, err 00.
- LB/LBU, addr 0x203, rdata 0x80AABBCC → LB rsp_data 0xFFFFFF80; LBU 0x00000080.
- SH, addr 0x302, wdata 0x1234ABCD, ack after 3 wait cycles → be 1100, wdata 0xABCDABCD, we 1, req held 4 cycles, rsp is_store=1, rd=0.
- Misaligned LW at 0x101 → no mem_req; rsp at T+1 with err 01. Store funct3 011 → err 11 (illegal beats misaligned).
- Timeout, TIMEOUT_CYCLES=4, no ack → req high exactly 4 cycles, rsp err 10. Ack on 4th cycle → err 00.
- Async rst asserted in MEM_WAIT → mem_req_o low immediately; late ack ignored; req_ready_o=1 after release.
